// File: rtl/seq_taillight_ctrl.sv
// Sequential N-lamp tail-light controller: left/right/hazard sweeps paced by an internal tick divider.
// Optional brake overlay is enabled by defining TAIL_BRAKE_EN.
module seq_taillight_ctrl #(
    parameter int unsigned LAMPS       = 3,
    parameter int unsigned SYSTEM_FREQ = 6250,
    parameter int unsigned HZ          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             haz,
    input  logic             brake,
    output logic [LAMPS-1:0] lights_l,
    output logic [LAMPS-1:0] lights_r,
    output logic             tick
);

    localparam int unsigned DIV    = SYSTEM_FREQ / HZ;
    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned STEP_W = $clog2(LAMPS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);

    typedef enum logic [1:0] {StIdle, StLeft, StRight, StHaz} state_t;

    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;
    logic [STEP_W-1:0] r_step;

    logic              w_tick;
    state_t            w_req;
    state_t            w_state_d;
    logic [STEP_W-1:0] w_step_d;
    logic [LAMPS-1:0]  w_mask;
    logic [LAMPS-1:0]  w_lights_l_d;
    logic [LAMPS-1:0]  w_lights_r_d;

    assign w_tick = (r_cnt == CNT_MAX);
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_ONE;
        end
    end

    always_comb begin
        if (haz || (left && right)) begin
            w_req = StHaz;
        end else if (left) begin
            w_req = StLeft;
        end else if (right) begin
            w_req = StRight;
        end else begin
            w_req = StIdle;
        end
    end

    // Requests only take effect at IDLE or the OFF step, except hazard preempting a turn.
    always_comb begin
        w_state_d = r_state;
        w_step_d  = r_step;
        if (w_tick) begin
            if (r_state == StIdle || r_step == '0) begin
                w_state_d = w_req;
                w_step_d  = (w_req == StIdle) ? '0 : STEP_ONE;
            end else if (r_state != StHaz && w_req == StHaz) begin
                w_state_d = StHaz;
                w_step_d  = STEP_ONE;
            end else if (r_state == StHaz || r_step == STEP_LAST) begin
                w_step_d  = '0;
            end else begin
                w_step_d  = r_step + STEP_ONE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LAMPS; i++) begin
            w_mask[i] = (i < int'(w_step_d));
        end
    end

    always_comb begin
        w_lights_l_d = '0;
        w_lights_r_d = '0;
        case (w_state_d)
            StLeft:  w_lights_l_d = w_mask;
            StRight: w_lights_r_d = w_mask;
            StHaz: begin
                if (w_step_d != '0) begin
                    w_lights_l_d = '1;
                    w_lights_r_d = '1;
                end
            end
            default: ;
        endcase
`ifdef TAIL_BRAKE_EN
        // Brake lights every side that is not sweeping; hazard wins over brake.
        if (brake) begin
            case (w_state_d)
                StIdle: begin
                    w_lights_l_d = '1;
                    w_lights_r_d = '1;
                end
                StLeft:  w_lights_r_d = '1;
                StRight: w_lights_l_d = '1;
                default: ;
            endcase
        end
`endif
    end

`ifndef TAIL_BRAKE_EN
    logic w_unused_brake;
    assign w_unused_brake = brake;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_step   <= '0;
            lights_l <= '0;
            lights_r <= '0;
        end else begin
            r_state  <= w_state_d;
            r_step   <= w_step_d;
            lights_l <= w_lights_l_d;
            lights_r <= w_lights_r_d;
        end
    end

endmodule
